// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the SDRAM port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;

    // Conventional requester IDs on the shared SDRAM port
    localparam int REQ_RUNENC = 0;
    localparam int REQ_BLOB   = 1;
    localparam int REQ_HOST   = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_tag_fifo.sv
// Small synchronous FIFO holding the requester ID of every outstanding read.
// Push and pop may happen in the same cycle, including while full.
module mem_arbiter_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot the push is about to use
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_reg];

    // storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM command port between NUM_REQ
// requesters, with a bounded burst lock and in-order read-data routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int MAX_BURST = 8,
    parameter int MAX_OUT   = 4,
    parameter int ID_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]        req_in_valid,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [DATA_W-1:0]         req_data_out,
    output logic [NUM_REQ-1:0]        req_out_valid,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_rw,
    output logic [DATA_W-1:0]         mem_data_in,
    output logic                      mem_in_valid,
    input  logic                      mem_busy,
    input  logic [DATA_W-1:0]         mem_data_out,
    input  logic                      mem_out_valid,
    output logic                      err
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t         state_reg;
    logic [ID_W-1:0]    owner_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [CNT_W-1:0]   burst_cnt_reg;

    logic [ADDR_W-1:0]  mem_addr_reg;
    logic               mem_rw_reg;
    logic [DATA_W-1:0]  mem_data_in_reg;
    logic               mem_in_valid_reg;
    logic [NUM_REQ-1:0] req_out_valid_reg;
    logic [DATA_W-1:0]  req_data_out_reg;
    logic               err_reg;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    logic               hold;
    logic               owner_dropped;
    logic [ID_W-1:0]    search_ptr;
    logic [ID_W:0]      probe;
    logic               found;
    logic [ID_W-1:0]    grant;
    logic               stage_free;
    logic               read_blocked;
    logic               accept;
    logic [NUM_REQ-1:0] busy_next;
    logic               others_valid;
    logic [CNT_W-1:0]   cnt_inc;
    logic               burst_done;

    logic               tag_full;
    logic               tag_empty;
    logic [ID_W-1:0]    tag_head;
    logic               tag_push;
    logic               pop_fire;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    // unpack the flat request buses into per-requester words
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_data_in[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // grant selection: keep the owner while it asserts valid, otherwise a
    // rotating search; a dropped owner re-arbitrates in the same cycle
    always_comb begin
        hold          = (state_reg == ST_LOCKED) && req_in_valid[owner_reg];
        owner_dropped = (state_reg == ST_LOCKED) && !req_in_valid[owner_reg];
        search_ptr    = owner_dropped ? wrap_inc(owner_reg) : rr_ptr_reg;
        found         = 1'b0;
        grant         = owner_reg;
        probe         = '0;
        if (hold) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                probe = {1'b0, search_ptr} + (ID_W+1)'(k);
                if (probe >= (ID_W+1)'(NUM_REQ)) begin
                    probe = probe - (ID_W+1)'(NUM_REQ);
                end
                if (!found && req_in_valid[probe[ID_W-1:0]]) begin
                    found = 1'b1;
                    grant = probe[ID_W-1:0];
                end
            end
        end
    end

    // handshake: only the granted requester can ever see busy low; reads
    // stall on a full tag FIFO but keep the grant
    always_comb begin
        stage_free   = ~mem_in_valid_reg | ~mem_busy;
        read_blocked = ~req_rw[grant] & tag_full;
        accept       = rst & found & stage_free & ~read_blocked;
        busy_next    = '1;
        if (rst && found) begin
            busy_next[grant] = ~(stage_free & ~read_blocked);
        end
        others_valid = |(req_in_valid & ~(NUM_REQ'(1) << grant));
        cnt_inc      = hold ? burst_cnt_reg + CNT_W'(1) : CNT_W'(1);
        burst_done   = (cnt_inc == CNT_W'(MAX_BURST));
    end

    assign req_busy = busy_next;

    // arbitration FSM: lock onto a requester, release on drop or burst limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            rr_ptr_reg <= search_ptr;
            if (accept) begin
                if (burst_done && others_valid) begin
                    state_reg     <= ST_IDLE;
                    rr_ptr_reg    <= wrap_inc(grant);
                    burst_cnt_reg <= '0;
                end else begin
                    state_reg     <= ST_LOCKED;
                    owner_reg     <= grant;
                    burst_cnt_reg <= burst_done ? '0 : cnt_inc;
                end
            end else if (owner_dropped) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    // command output register toward the SDRAM controller
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_in_valid_reg <= 1'b0;
            mem_addr_reg     <= '0;
            mem_rw_reg       <= 1'b0;
            mem_data_in_reg  <= '0;
        end else if (accept) begin
            mem_in_valid_reg <= 1'b1;
            mem_addr_reg     <= addr_arr[grant];
            mem_rw_reg       <= req_rw[grant];
            mem_data_in_reg  <= wdata_arr[grant];
        end else if (stage_free) begin
            mem_in_valid_reg <= 1'b0;
        end
    end

    assign tag_push = accept & ~req_rw[grant];
    assign pop_fire = mem_out_valid & ~tag_empty;

    mem_arbiter_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_push),
        .push_data (grant),
        .pop       (mem_out_valid),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // read return: route data to the oldest outstanding reader, flag strays
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_out_valid_reg <= '0;
            req_data_out_reg  <= '0;
            err_reg           <= 1'b0;
        end else begin
            if (pop_fire) begin
                req_out_valid_reg <= NUM_REQ'(1) << tag_head;
                req_data_out_reg  <= mem_data_out;
            end else begin
                req_out_valid_reg <= '0;
            end
            if (mem_out_valid && tag_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign mem_addr      = mem_addr_reg;
    assign mem_rw        = mem_rw_reg;
    assign mem_data_in   = mem_data_in_reg;
    assign mem_in_valid  = mem_in_valid_reg;
    assign req_out_valid = req_out_valid_reg;
    assign req_data_out  = req_data_out_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int MB = 8;
    localparam int MO = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N*ADDR_W-1:0] req_addr = '0;
    logic [N-1:0]        req_rw = '0;
    logic [N*DATA_W-1:0] req_data_in = '0;
    logic [N-1:0]        req_in_valid = '0;
    logic [N-1:0]        req_busy;
    logic [DATA_W-1:0]   req_data_out;
    logic [N-1:0]        req_out_valid;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rw;
    logic [DATA_W-1:0]   mem_data_in;
    logic                mem_in_valid;
    logic                mem_busy = 1'b0;
    logic [DATA_W-1:0]   mem_data_out = '0;
    logic                mem_out_valid = 1'b0;
    logic                err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ   (N),
        .MAX_BURST (MB),
        .MAX_OUT   (MO),
        .ID_W      (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_addr      (req_addr),
        .req_rw        (req_rw),
        .req_data_in   (req_data_in),
        .req_in_valid  (req_in_valid),
        .req_busy      (req_busy),
        .req_data_out  (req_data_out),
        .req_out_valid (req_out_valid),
        .mem_addr      (mem_addr),
        .mem_rw        (mem_rw),
        .mem_data_in   (mem_data_in),
        .mem_in_valid  (mem_in_valid),
        .mem_busy      (mem_busy),
        .mem_data_out  (mem_data_out),
        .mem_out_valid (mem_out_valid),
        .err           (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // behavioural model: who holds the port, how many beats, where the
    // rotation resumes, which readers are still waiting, and the outputs
    bit                m_locked;
    int                m_owner;
    int                m_ptr;
    int                m_beats;
    int                tags[$];
    bit                e_mv;
    bit                e_rw;
    bit                e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [DATA_W-1:0] e_rdata;
    logic [N-1:0]      e_ov;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_beats  = 0;
        tags.delete();
        e_mv     = 1'b0;
        e_rw     = 1'b0;
        e_err    = 1'b0;
        e_addr   = '0;
        e_wdata  = '0;
        e_rdata  = '0;
        e_ov     = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit rw,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_in_valid[i]                  = v;
        req_rw[i]                        = rw;
        req_addr[i*ADDR_W +: ADDR_W]     = a;
        req_data_in[i*DATA_W +: DATA_W]  = d;
    endtask

    task automatic clear_inputs();
        req_in_valid  = '0;
        req_rw        = '0;
        req_addr      = '0;
        req_data_in   = '0;
        mem_busy      = 1'b0;
        mem_out_valid = 1'b0;
        mem_data_out  = '0;
    endtask

    // one clock: compare all outputs against the model, then advance the
    // model with the rules of the arbiter and wait for the next cycle
    task automatic step();
        int gr;
        int start;
        int beats;
        int h;
        bit acc;
        bit full;
        bit others;
        bit sfree;
        logic [N-1:0] eb;
        #1;
        gr = -1;
        if (m_locked && req_in_valid[m_owner]) begin
            gr = m_owner;
        end else begin
            start = m_locked ? (m_owner + 1) % N : m_ptr;
            for (int k = 0; k < N; k++) begin
                if (gr < 0 && req_in_valid[(start + k) % N]) gr = (start + k) % N;
            end
        end
        sfree = !e_mv || !mem_busy;
        full  = (tags.size() == MO);
        eb    = '1;
        acc   = 1'b0;
        if (gr >= 0 && sfree && !(req_rw[gr] == 1'b0 && full)) begin
            eb[gr] = 1'b0;
            acc    = 1'b1;
        end
        check("req_busy", req_busy, eb);
        check("mem_in_valid", mem_in_valid, e_mv);
        check("mem_addr", mem_addr, e_addr);
        check("mem_rw", mem_rw, e_rw);
        check("mem_data_in", mem_data_in, e_wdata);
        check("req_out_valid", req_out_valid, e_ov);
        check("req_data_out", req_data_out, e_rdata);
        check("err", err, e_err);

        if (m_locked && !req_in_valid[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % N;
        end
        if (acc) begin
            beats  = ((m_locked && gr == m_owner) ? m_beats : 0) + 1;
            others = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (k != gr && req_in_valid[k]) others = 1'b1;
            end
            if (beats == MB && others) begin
                m_locked = 1'b0;
                m_ptr    = (gr + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_owner  = gr;
                m_beats  = (beats == MB) ? 0 : beats;
            end
            e_mv    = 1'b1;
            e_addr  = req_addr[gr*ADDR_W +: ADDR_W];
            e_rw    = req_rw[gr];
            e_wdata = req_data_in[gr*DATA_W +: DATA_W];
        end else if (sfree) begin
            e_mv = 1'b0;
        end
        if (mem_out_valid && tags.size() > 0) begin
            h       = tags.pop_front();
            e_ov    = N'(1) << h;
            e_rdata = mem_data_out;
        end else begin
            e_ov = '0;
            if (mem_out_valid) e_err = 1'b1;
        end
        if (acc && !req_rw[gr]) tags.push_back(gr);
        @(posedge clk);
        @(negedge clk);
    endtask

    // asynchronous reset between clock edges, checked before any edge
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_req_busy", req_busy, 3'b111);
        check("rst_mem_in_valid", mem_in_valid, 1'b0);
        check("rst_req_out_valid", req_out_valid, 3'b000);
        check("rst_req_data_out", req_data_out, 32'h0);
        check("rst_mem_addr", mem_addr, 23'h0);
        check("rst_mem_rw", mem_rw, 1'b0);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        check("rst_err", err, 1'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // single read from the blob detector
        do_reset();
        clear_inputs();
        set_req(REQ_BLOB, 1'b1, 1'b0, 23'h000100, 32'h0);
        step();
        check("single_mem_valid", mem_in_valid, 1'b1);
        check("single_mem_addr", mem_addr, 23'h000100);
        check("single_mem_rw", mem_rw, 1'b0);
        clear_inputs();
        mem_out_valid = 1'b1;
        mem_data_out  = 32'hDEADBEEF;
        step();
        mem_out_valid = 1'b0;
        check("single_strobe", req_out_valid, 3'b010);
        check("single_data", req_data_out, 32'hDEADBEEF);
        step();

        // three-way contention: 8 beats each in rotation
        do_reset();
        clear_inputs();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 23'(i), 32'(100 + i));
        for (int i = 0; i < 25; i++) begin
            step();
            check("contend_owner", mem_addr, 23'((i / 8) % 3));
        end

        // back-pressure mid-burst
        do_reset();
        clear_inputs();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 23'(i), 32'(200 + i));
        repeat (3) step();
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_busy", req_busy, 3'b111);
            check("bp_hold_valid", mem_in_valid, 1'b1);
            check("bp_hold_addr", mem_addr, 23'h0);
        end
        mem_busy = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step();
            check("bp_resume_owner", mem_addr, (j < 5) ? 23'h0 : 23'h1);
        end

        // tag FIFO full
        do_reset();
        clear_inputs();
        set_req(1, 1'b1, 1'b0, 23'h000200, 32'h0);
        repeat (4) step();
        #1;
        check("full_read_busy", req_busy, 3'b111);
        set_req(1, 1'b0, 1'b0, 23'h000200, 32'h0);
        set_req(0, 1'b1, 1'b1, 23'h000300, 32'h12345678);
        #1;
        check("full_write_ok", req_busy, 3'b110);
        step();
        check("full_write_rw", mem_rw, 1'b1);
        check("full_write_addr", mem_addr, 23'h000300);
        set_req(0, 1'b0, 1'b1, 23'h000300, 32'h0);
        set_req(1, 1'b1, 1'b0, 23'h000204, 32'h0);
        mem_out_valid = 1'b1;
        mem_data_out  = 32'hCAFE0001;
        #1;
        check("full_still_busy", req_busy, 3'b111);
        step();
        mem_out_valid = 1'b0;
        check("full_pop_strobe", req_out_valid, 3'b010);
        #1;
        check("full_freed", req_busy, 3'b101);
        step();
        check("full_read_addr", mem_addr, 23'h000204);
        check("full_read_rw", mem_rw, 1'b0);

        // interleaved reads return in issue order
        do_reset();
        clear_inputs();
        set_req(0, 1'b1, 1'b0, 23'h000010, 32'h0);
        step();
        set_req(0, 1'b0, 1'b0, 23'h0, 32'h0);
        set_req(2, 1'b1, 1'b0, 23'h000020, 32'h0);
        step();
        check("il_second_addr", mem_addr, 23'h000020);
        set_req(2, 1'b0, 1'b0, 23'h0, 32'h0);
        set_req(0, 1'b1, 1'b0, 23'h000030, 32'h0);
        step();
        check("il_third_addr", mem_addr, 23'h000030);
        clear_inputs();
        mem_out_valid = 1'b1;
        mem_data_out  = 32'h11;
        step();
        check("il_strobe1", req_out_valid, 3'b001);
        check("il_data1", req_data_out, 32'h11);
        mem_data_out = 32'h22;
        step();
        check("il_strobe2", req_out_valid, 3'b100);
        check("il_data2", req_data_out, 32'h22);
        mem_data_out = 32'h33;
        step();
        check("il_strobe3", req_out_valid, 3'b001);
        check("il_data3", req_data_out, 32'h33);
        mem_out_valid = 1'b0;
        step();
        check("il_idle", req_out_valid, 3'b000);

        // stray response sets the sticky error
        do_reset();
        clear_inputs();
        mem_out_valid = 1'b1;
        mem_data_out  = 32'h55AA55AA;
        step();
        mem_out_valid = 1'b0;
        check("stray_err", err, 1'b1);
        check("stray_no_strobe", req_out_valid, 3'b000);
        repeat (2) step();
        check("stray_err_sticky", err, 1'b1);

        // reset in the middle of a burst
        set_req(0, 1'b1, 1'b1, 23'h000777, 32'hA5A5A5A5);
        repeat (3) step();
        do_reset();
        clear_inputs();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req_in_valid[i] = ($urandom_range(0, 3) != 0);
                req_rw[i] = $urandom_range(0, 1) != 0;
                req_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'($urandom);
                req_data_in[i*DATA_W +: DATA_W] = $urandom;
            end
            mem_busy      = ($urandom_range(0, 3) == 0);
            mem_out_valid = (tags.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_data_out  = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 32-bit SDRAM port (23-bit word address) between NUM_REQ requesters, e.g. run encoder writes (req 0), blob_detector reads/writes (req 1), host/SPI readback (req 2).
- Round-robin arbitration with a bounded burst lock.
- A tag FIFO records the issuing requester of every read, so each read response returns to the requester that issued it.
- Sits between the processing blocks and the SDRAM controller; both sides use the same addr/rw/data/busy/valid handshake.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 8, max consecutive beats one requester keeps the grant while others wait.
- MAX_OUT, 4, depth of the outstanding-read tag FIFO (power of 2).
- ID_W, 2, width of a requester ID; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_addr  in  NUM_REQ*23  packed request addresses; requester i uses bits [23*i+:23].
- req_rw  in  NUM_REQ  1 = write, 0 = read.
- req_data_in  in  NUM_REQ*32  packed write data.
- req_in_valid  in  NUM_REQ  request present.
- req_busy  out  NUM_REQ  back-pressure; a request is accepted when in_valid=1 and busy=0 on a rising edge.
- req_data_out  out  32  read data, shared by all requesters.
- req_out_valid  out  NUM_REQ  one-hot read-data strobe.
- mem_addr  out  23  address to SDRAM controller.
- mem_rw  out  1  read/write to SDRAM controller.
- mem_data_in  out  32  write data to SDRAM controller.
- mem_in_valid  out  1  command valid.
- mem_busy  in  1  SDRAM controller back-pressure.
- mem_data_out  in  32  read data from SDRAM controller.
- mem_out_valid  in  1  read data valid.
- err  out  1  sticky: read data arrived with no outstanding tag.

Behaviour:
- Reset values (rst low, asynchronous): req_busy all 1; mem_in_valid 0; req_out_valid 0; req_data_out 0; mem_addr/mem_rw/mem_data_in 0; err 0; rr_ptr 0; burst_cnt 0; tag FIFO empty.

Command stage:
- One output register holding mem_addr, mem_rw, mem_data_in and mem_in_valid.
- stage_free = ~mem_in_valid | ~mem_busy.
- Grant is combinational from the current request inputs; requester g = grant.
- req_busy[g] = ~(stage_free & ~(~req_rw[g] & tag_full)). Every other req_busy bit is 1.
- On acceptance, the stage loads requester g's command on the next edge, so mem_in_valid rises 1 cycle after acceptance.
- Full throughput: one command per cycle while mem_busy=0.
- Stage unloads (mem_in_valid falls) when mem_in_valid=1, mem_busy=0 and no new acceptance.
- Writes are never blocked by tag_full; reads are. A blocked read holds the grant and is not skipped.

Arbitration states: IDLE, LOCKED.
- IDLE: grant = first requester with in_valid, searching from rr_ptr upward with wrap from NUM_REQ-1 to 0. On acceptance: go to LOCKED with owner = g and burst_cnt = 1.
- LOCKED: grant = owner while req_in_valid[owner]=1. Each acceptance increments burst_cnt.
- Owner drops in_valid: return to IDLE; rr_ptr = owner+1 (mod NUM_REQ); re-arbitrate in the same cycle.
- burst_cnt reaches MAX_BURST and another requester is valid: rr_ptr = owner+1, go to IDLE. The owner loses the grant for at least that next arbitration.
- burst_cnt reaches MAX_BURST with no contender: burst_cnt wraps to 0 and the owner keeps the grant.
- Stalls (stage not free) do not advance burst_cnt.

Read return:
- An accepted read pushes g into the tag FIFO.
- mem_out_valid pops the head tag h. Next cycle: req_out_valid[h]=1 and req_data_out = mem_data_out. Latency 1.
- Push and pop in the same cycle are legal even when full; count is unchanged.
- mem_out_valid with the FIFO empty: sets err, no strobe, no pop.
- Read data is returned in issue order; the SDRAM controller returns reads in order.

Reset mid-operation: all state is cleared immediately; in-flight reads are dropped.

Decomposition:
- Shared package/header holds ADDR_W=23 and DATA_W=32 constants and the requester-ID constants REQ_RUNENC=0, REQ_BLOB=1, REQ_HOST=2.
- Sub-module tag_fifo: synchronous FIFO, width ID_W, depth MAX_OUT, with full/empty flags and push/pop in the same cycle.

Test Plan:
- Single read: req1 read addr 0x000100 -> mem_in_valid 1 cycle after acceptance with mem_addr=0x000100, mem_rw=0. mem_out_valid with data 0xDEADBEEF -> next cycle req_out_valid=3'b010, req_data_out=0xDEADBEEF.
- Contention: all three requesters hold in_valid with MAX_BURST=8 -> grants come as 8 beats req0, 8 beats req1, 8 beats req2, then req0; no requester is starved.
- Back-pressure: mem_busy high 5 cycles mid-burst -> command stage holds, all req_busy=1, burst_cnt frozen, no command lost or duplicated.
- Tag full: 4 reads issued with no response -> 5th read sees req_busy=1. A write from another requester is still accepted. One response -> read accepted next cycle.
- Interleaved reads: req0, req2, req0 reads, responses 0x11, 0x22, 0x33 -> strobes 001, 100, 001 with matching data.
- Stray response and reset: mem_out_valid with FIFO empty -> err=1 until reset. Assert rst low mid-burst -> all outputs at reset values immediately.
